// File: rtl/xilinx_primitive_pkg.sv
// Shared constants and helpers for Xilinx block-RAM primitive wrappers.
// Pin widths here match the 36Kb single-port BRAM macro.
package xilinx_primitive_pkg;

    localparam int BRAM_ADDR_W = 15;
    localparam int BRAM_WE_W   = 8;

    // Cycles from EN at the BRAM to valid DO.
    function automatic int unsigned bram_rd_latency(input int unsigned do_reg);
        return 1 + do_reg;
    endfunction

endpackage

// File: rtl/xilinx_bram_rsp_fifo.sv
// Synchronous response FIFO; the head entry is read straight from its register.
// A push into a full FIFO is taken only together with a pop.
module xilinx_bram_rsp_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNTW'(DEPTH));
    assign dout_o  = mem_q[rp_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wp_d  = wp_q + AW'(do_push);
        rp_d  = rp_q + AW'(do_pop);
        cnt_d = cnt_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din_i;
            end
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xilinx_sp_bram_ctrl.sv
// Valid/ready command front-end for a single-port BRAM with credit-based read return.
// Define XILINX_SP_BRAM_CTRL_WACK_EN to acknowledge writes through the response port.
module xilinx_sp_bram_ctrl
    import xilinx_primitive_pkg::*;
#(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 10,
    parameter int WE_WIDTH   = 4,
    parameter int DO_REG     = 0,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic                   CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0]  CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]  CMD_WDATA,
    input  logic [WE_WIDTH-1:0]    CMD_WSTRB,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [DATA_WIDTH-1:0]  RSP_RDATA,
    output logic                   RSP_WRITE,
    output logic                   BRAM_EN,
    output logic [BRAM_ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]  BRAM_DI,
    output logic [BRAM_WE_W-1:0]   BRAM_WE,
    output logic                   BRAM_REGCE,
    output logic                   BRAM_RST,
    input  logic [DATA_WIDTH-1:0]  BRAM_DO
);

    localparam int LAT = bram_rd_latency(DO_REG);
    localparam int CW  = $clog2(RSP_DEPTH) + 1;

    typedef struct packed {
        logic                  write;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic          accept;
    logic          tag_take;
    logic          tag_wr;
    logic          pop;
    logic [CW-1:0] credit_q, credit_d;
    logic [LAT-1:0] tv_q, tv_d;
    logic [LAT-1:0] tw_q, tw_d;
    rsp_t          push_rsp;
    rsp_t          head;
    logic          fifo_empty;
    logic          fifo_full_unused;

    assign CMD_READY = RST_N && (credit_q != '0);
    assign accept    = CMD_VALID && CMD_READY;
    assign pop       = RSP_VALID && RSP_READY;

`ifdef XILINX_SP_BRAM_CTRL_WACK_EN
    assign tag_take = accept;
    assign tag_wr   = CMD_WRITE;
`else
    assign tag_take = accept && !CMD_WRITE;
    assign tag_wr   = 1'b0;
`endif

    assign BRAM_EN    = accept;
    assign BRAM_WE    = (accept && CMD_WRITE) ? BRAM_WE_W'(CMD_WSTRB) : '0;
    assign BRAM_ADDR  = BRAM_ADDR_W'(CMD_ADDR);
    assign BRAM_DI    = CMD_WDATA;
    assign BRAM_REGCE = 1'b1;
    assign BRAM_RST   = !RST_N;

    // Every credit is a reserved FIFO slot, so a tag leaving the pipe always fits.
    always_comb begin
        credit_d = credit_q;
        unique case ({tag_take, pop})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        tv_d    = tv_q;
        tw_d    = tw_q;
        tv_d[0] = tag_take;
        tw_d[0] = tag_wr;
        for (int i = 1; i < LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tw_d[i] = tw_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            credit_q <= CW'(RSP_DEPTH);
            tv_q     <= '0;
            tw_q     <= '0;
        end else begin
            credit_q <= credit_d;
            tv_q     <= tv_d;
            tw_q     <= tw_d;
        end
    end

    always_comb begin
        push_rsp.write = tw_q[LAT-1];
        push_rsp.data  = tw_q[LAT-1] ? '0 : BRAM_DO;
    end

    xilinx_bram_rsp_fifo #(
        .W     ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (tv_q[LAT-1]),
        .din_i   (push_rsp),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full_unused),
        .empty_o (fifo_empty)
    );

    assign RSP_VALID = !fifo_empty;
    assign RSP_RDATA = head.data;
    assign RSP_WRITE = head.write;

endmodule

// File: tb/tb_xilinx_sp_bram_ctrl.sv
// Self-checking bench for xilinx_sp_bram_ctrl with a behavioural single-port BRAM.
// Expected responses come from a shadow memory and are scoreboarded in order.
module tb_xilinx_sp_bram_ctrl;

    localparam int DW    = 36;
    localparam int AW    = 10;
    localparam int WEW   = 4;
    localparam int DOREG = 0;
    localparam int DEPTH = 4;
    localparam int LANE  = DW / WEW;
    localparam int LAT   = 1 + DOREG;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [WEW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_write;
    logic          bram_en;
    logic [14:0]   bram_addr;
    logic [DW-1:0] bram_di;
    logic [7:0]    bram_we;
    logic          bram_regce;
    logic          bram_rst;
    logic [DW-1:0] bram_do;

    typedef struct {
        logic          w;
        logic [DW-1:0] d;
        int            cyc;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          got_q[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] do_lat;
    logic [DW-1:0] do_reg_q;
    int            vectors = 0;
    int            errors  = 0;
    int            cyc     = 0;

    always #5 clk = ~clk;

    xilinx_sp_bram_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WE_WIDTH   (WEW),
        .DO_REG     (DOREG),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_WRITE  (cmd_write),
        .CMD_ADDR   (cmd_addr),
        .CMD_WDATA  (cmd_wdata),
        .CMD_WSTRB  (cmd_wstrb),
        .RSP_VALID  (rsp_valid),
        .RSP_READY  (rsp_ready),
        .RSP_RDATA  (rsp_rdata),
        .RSP_WRITE  (rsp_write),
        .BRAM_EN    (bram_en),
        .BRAM_ADDR  (bram_addr),
        .BRAM_DI    (bram_di),
        .BRAM_WE    (bram_we),
        .BRAM_REGCE (bram_regce),
        .BRAM_RST   (bram_rst),
        .BRAM_DO    (bram_do)
    );

    // Read-first single-port BRAM with optional output register.
    always @(posedge clk) begin
        if (bram_rst) begin
            do_lat <= '0;
        end else if (bram_en) begin
            do_lat <= mem[bram_addr[AW-1:0]];
            for (int l = 0; l < WEW; l++) begin
                if (bram_we[l]) begin
                    mem[bram_addr[AW-1:0]][l*LANE +: LANE] <= bram_di[l*LANE +: LANE];
                end
            end
        end
        if (bram_rst) begin
            do_reg_q <= '0;
        end else if (bram_regce) begin
            do_reg_q <= do_lat;
        end
    end

    assign bram_do = (DOREG != 0) ? do_reg_q : do_lat;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                            input logic [DW-1:0] n,
                                            input logic [WEW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int l = 0; l < WEW; l++) begin
            if (s[l]) begin
                r[l*LANE +: LANE] = n[l*LANE +: LANE];
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic w, input int a,
                         input logic [DW-1:0] d, input logic [WEW-1:0] s);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = AW'(a);
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    // One clock: record accepted commands as expectations, popped responses as actuals.
    task automatic step(output bit acc);
        #1;
        acc = cmd_valid && cmd_ready;
        if (acc) begin
            if (cmd_write) begin
                shadow[cmd_addr] = merge(shadow[cmd_addr], cmd_wdata, cmd_wstrb);
`ifdef XILINX_SP_BRAM_CTRL_WACK_EN
                exp_q.push_back('{w: 1'b1, d: DW'(0), cyc: cyc});
`endif
            end else begin
                exp_q.push_back('{w: 1'b0, d: shadow[cmd_addr], cyc: cyc});
            end
        end
        if (rsp_valid && rsp_ready) begin
            got_q.push_back('{w: rsp_write, d: rsp_rdata, cyc: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a;
        drive(1'b0, 1'b0, 0, '0, '0);
        repeat (n) step(a);
    endtask

    task automatic test_reset();
        bit a;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 3, '1, '1);
        repeat (3) step(a);
        vectors++;
        if (cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready);
        end
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_write !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got v=%b w=%b want 0/0", rsp_valid, rsp_write);
        end
        vectors++;
        if (rsp_rdata !== DW'(0)) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rsp_rdata);
        end
        vectors++;
        if (bram_en !== 1'b0 || bram_we !== 8'h00 || bram_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_bram got en=%b we=%h rst=%b want 0/00/1", bram_en, bram_we, bram_rst);
        end
        drive(1'b0, 1'b0, 0, '0, '0);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || bram_rst !== 1'b0) begin
            errors++; $display("FAIL release_ready got rdy=%b rst=%b want 1/0", cmd_ready, bram_rst);
        end
        idle(1);
    endtask

    task automatic test_write_read();
        bit   a;
        rec_t g, e;
        drive(1'b1, 1'b1, 5, 36'h123456789, 4'hF);
        #1;
        vectors++;
        if (bram_en !== 1'b1 || bram_we !== 8'h0F || bram_addr !== 15'd5 || bram_di !== 36'h123456789) begin
            errors++;
            $display("FAIL wr_pins got en=%b we=%h a=%h di=%h want 1/0f/0005/123456789",
                     bram_en, bram_we, bram_addr, bram_di);
        end
        step(a);
        drive(1'b1, 1'b0, 5, '0, '0);
        #1;
        vectors++;
        if (bram_en !== 1'b1 || bram_we !== 8'h00) begin
            errors++; $display("FAIL rd_pins got en=%b we=%h want 1/00", bram_en, bram_we);
        end
        step(a);
        idle(6);
        vectors++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
            errors++; $display("FAIL wr_rd_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g.w !== e.w || g.d !== e.d || g.cyc - e.cyc != LAT + 1) begin
                errors++;
                $display("FAIL wr_rd_rsp got w=%b d=%h lat=%0d want w=%b d=%h lat=%0d",
                         g.w, g.d, g.cyc - e.cyc, e.w, e.d, LAT + 1);
            end
            if (!g.w) begin
                vectors++;
                if (g.d !== 36'h123456789) begin
                    errors++; $display("FAIL wr_rd_data got %h want 123456789", g.d);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_strobe();
        bit   a;
        rec_t g, e;
        drive(1'b1, 1'b1, 9, '1, 4'hF);
        step(a);
        drive(1'b1, 1'b1, 9, '0, 4'b0010);
        step(a);
        drive(1'b1, 1'b0, 9, '0, '0);
        step(a);
        idle(6);
        vectors++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
            errors++; $display("FAIL strobe_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g.w !== e.w || g.d !== e.d) begin
                errors++; $display("FAIL strobe_rsp got w=%b d=%h want w=%b d=%h", g.w, g.d, e.w, e.d);
            end
            if (!g.w) begin
                vectors++;
                if (g.d !== 36'hFFFFC01FF) begin
                    errors++; $display("FAIL strobe_lane1 got %h want ffffc01ff", g.d);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit   a;
        int   i;
        int   k;
        int   stalls;
        rec_t g, e;
        rsp_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 1'b1, j, DW'(j * 3), 4'hF);
            step(a);
        end
        idle(6);
        got_q.delete();
        exp_q.delete();
        i      = 0;
        stalls = 0;
        for (int t = 0; t < 30 && i < 8; t++) begin
            drive(1'b1, 1'b0, i, '0, '0);
            step(a);
            if (a) i++;
            else stalls++;
        end
        idle(8);
        vectors++;
        if (i != 8 || stalls != 0) begin
            errors++; $display("FAIL b2b_issue got %0d reads %0d stalls want 8/0", i, stalls);
        end
        vectors++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            errors++; $display("FAIL b2b_count got %0d want 8 (exp %0d)", got_q.size(), exp_q.size());
        end
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g.w !== 1'b0 || g.d !== DW'(k * 3) || g.d !== e.d || g.cyc - e.cyc != LAT + 1) begin
                errors++;
                $display("FAIL b2b_rsp%0d got d=%h lat=%0d want d=%h lat=%0d",
                         k, g.d, g.cyc - e.cyc, DW'(k * 3), LAT + 1);
            end
            k++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit            a;
        int            i;
        int            k;
        logic [DW-1:0] held;
        rec_t          g, e;
        rsp_ready = 1'b0;
        i = 0;
        for (int t = 0; t < 10; t++) begin
            drive(1'b1, 1'b0, 2 + i, '0, '0);
            step(a);
            if (a) i++;
        end
        vectors++;
        if (i != DEPTH || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepts got %0d rdy=%b want %0d/0", i, cmd_ready, DEPTH);
        end
        held = rsp_rdata;
        step(a);
        step(a);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== held || held !== DW'(6)) begin
            errors++;
            $display("FAIL bp_stable got v=%b d=%h held=%h want 1/%h", rsp_valid, rsp_rdata, held, DW'(6));
        end
        rsp_ready = 1'b1;
        for (int t = 0; t < 20 && i < 6; t++) begin
            drive(1'b1, 1'b0, 2 + i, '0, '0);
            step(a);
            if (a) i++;
        end
        idle(8);
        vectors++;
        if (i != 6 || got_q.size() != 6 || exp_q.size() != 6) begin
            errors++; $display("FAIL bp_count got %0d/%0d want 6/6", i, got_q.size());
        end
        k = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g.w !== 1'b0 || g.d !== e.d || g.d !== DW'((2 + k) * 3)) begin
                errors++; $display("FAIL bp_rsp%0d got %h want %h", k, g.d, DW'((2 + k) * 3));
            end
            k++;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit   a;
        int   n;
        rec_t g, e;
        rsp_ready = 1'b0;
        n = 0;
        for (int j = 1; j <= 3; j++) begin
            drive(1'b1, 1'b0, j, '0, '0);
            step(a);
            if (a) n++;
        end
        drive(1'b0, 1'b0, 0, '0, '0);
        step(a);
        rst_n = 1'b0;
        step(a);
        vectors++;
        if (n != 3 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_flush got acc=%0d v=%b want 3/0", n, rsp_valid);
        end
        exp_q.delete();
        got_q.delete();
        step(a);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        idle(5);
        vectors++;
        if (got_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_stale got %0d rsps v=%b want 0/0", got_q.size(), rsp_valid);
        end
        rsp_ready = 1'b0;
        n = 0;
        for (int t = 0; t < 8; t++) begin
            drive(1'b1, 1'b0, 4, '0, '0);
            step(a);
            if (a) n++;
        end
        vectors++;
        if (n != DEPTH) begin
            errors++; $display("FAIL rst_credit got %0d want %0d", n, DEPTH);
        end
        rsp_ready = 1'b1;
        idle(8);
        vectors++;
        if (got_q.size() != DEPTH || exp_q.size() != DEPTH) begin
            errors++; $display("FAIL rst_count got %0d want %0d", got_q.size(), DEPTH);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (g.w !== 1'b0 || g.d !== e.d || g.d !== DW'(12)) begin
                errors++; $display("FAIL rst_rsp got %h want %h", g.d, DW'(12));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

`ifdef XILINX_SP_BRAM_CTRL_WACK_EN
    task automatic test_wack();
        bit   a;
        rec_t g;
        rsp_ready = 1'b1;
        drive(1'b1, 1'b1, 20, 36'hABCDE1234, 4'hF);
        step(a);
        drive(1'b1, 1'b0, 20, '0, '0);
        step(a);
        idle(6);
        vectors++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL wack_count got %0d want 2", got_q.size());
        end
        if (got_q.size() == 2) begin
            g = got_q.pop_front();
            vectors++;
            if (g.w !== 1'b1 || g.d !== DW'(0)) begin
                errors++; $display("FAIL wack_ack got w=%b d=%h want 1/0", g.w, g.d);
            end
            g = got_q.pop_front();
            vectors++;
            if (g.w !== 1'b0 || g.d !== 36'hABCDE1234) begin
                errors++; $display("FAIL wack_rd got w=%b d=%h want 0/abcde1234", g.w, g.d);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 0, '0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_strobe();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef XILINX_SP_BRAM_CTRL_WACK_EN
        test_wack();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
